// File: rtl/seq_chunked_adder.sv
// Multi-cycle ripple-carry adder: adds two WIDTH-bit operands CHUNK bits per clock,
// carrying between chunks in a register, with a start/busy/done handshake and signed overflow.
module seq_chunked_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry;
    logic [IDXW-1:0]  idx;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_sum;
    logic             last;
    logic             msb_carry_in;

    assign a_chunk   = a_reg[int'(idx)*CHUNK +: CHUNK];
    assign b_chunk   = b_reg[int'(idx)*CHUNK +: CHUNK];
    assign chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry};
    assign last      = (int'(idx) == NCHUNK - 1);
    assign busy      = (state == RUN);

    // Carry into the top bit recovered from its sum bit: s = a ^ b ^ cin.
    assign msb_carry_in = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_sum[CHUNK-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            c_out <= 1'b0;
            ovf   <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= in1;
                        b_reg <= in2;
                        carry <= c_in;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    sum[int'(idx)*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
                    carry <= chunk_sum[CHUNK];
                    if (last) begin
                        c_out <= chunk_sum[CHUNK];
                        ovf   <= msb_carry_in ^ chunk_sum[CHUNK];
                        done  <= 1'b1;
                        idx   <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                        // Stale flags of the previous result go away once a new one is underway.
                        if (idx == '0) begin
                            c_out <= 1'b0;
                            ovf   <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
